// File: rtl/ram_fifo_if.sv
// Bus-side bundle for ram_fifo: write/read requests, data and status.
// The master drives requests; the slave (the FIFO) returns data and flags.
interface ram_fifo_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 256
);
    localparam int unsigned CBITS = $clog2(DEPTH + 1);

    logic             clear;
    logic [WIDTH-1:0] din;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CBITS-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, din, push, pop,
        input  dout, dout_valid, full, empty, almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  clear, din, push, pop,
        output dout, dout_valid, full, empty, almost_full, almost_empty, count,
        output overflow, underflow
    );
endinterface

// File: rtl/ram_fifo.sv
// Single-clock FIFO over an inferred simple dual-port RAM, with any DEPTH >= 2,
// occupancy/almost flags, sticky overflow/underflow and synchronous clear.
module ram_fifo #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 256,
    parameter int          AF_LEVEL = int'(DEPTH) - 4,
    parameter int          AE_LEVEL = 4
) (
    input logic      clock,
    input logic      reset_n,
    ram_fifo_if.slave bus
);
    localparam int unsigned ABITS = $clog2(DEPTH);
    localparam int unsigned CBITS = $clog2(DEPTH + 1);
    localparam logic [ABITS-1:0] LAST_PTR = ABITS'(DEPTH - 1);
    localparam logic [CBITS-1:0] FULL_CNT = CBITS'(DEPTH);
    // Negative thresholds (tiny DEPTH) clamp to zero so the compare stays unsigned.
    localparam int unsigned AF_U = (AF_LEVEL < 0) ? 0 : AF_LEVEL;
    localparam int unsigned AE_U = (AE_LEVEL < 0) ? 0 : AE_LEVEL;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [ABITS-1:0] r_wr_ptr;
    logic [ABITS-1:0] r_rd_ptr;
    logic [CBITS-1:0] r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    function automatic logic [ABITS-1:0] f_next(input logic [ABITS-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ABITS'(1);
    endfunction

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // A clear cycle swallows both requests, so nothing is accepted or flagged.
    assign w_pop_ok  = bus.pop  & ~w_empty & ~bus.clear;
    assign w_push_ok = bus.push & ~bus.clear & (~w_full | w_pop_ok);

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_dout_valid <= w_pop_ok;
            if (w_pop_ok) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            if (w_push_ok) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CBITS'(1);
                2'b01:   r_count <= r_count - CBITS'(1);
                default: r_count <= r_count;
            endcase
            if (bus.push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (bus.pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.dout         = r_dout;
    assign bus.dout_valid   = r_dout_valid;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (32'(r_count) >= AF_U);
    assign bus.almost_empty = (32'(r_count) <= AE_U);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: doc/ram_fifo.md
Name: ram_fifo

Overview:
Parametrised single-clock FIFO built on an inferred simple dual-port RAM array. It is the buffered successor to the plain dual-port RAM. It adds:
- internal wrap-around pointers, including non-power-of-2 depth
- occupancy count and full/empty/almost flags
- sticky overflow/underflow error flags
- synchronous clear

It sits between the bus-side register interface and the protocol engines as the standard TX/RX data buffer.

Parameters:
WIDTH, 16, data word width in bits (>=1).
DEPTH, 256, number of storage words (>=2; need not be a power of 2).
AF_LEVEL, DEPTH-4, almost_full asserted when count >= AF_LEVEL.
AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL.
Derived: ABITS = $clog2(DEPTH), CBITS = $clog2(DEPTH+1).

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous flush of pointers, count and error flags.
din  input  WIDTH  write data.
push  input  1  write request.
pop  input  1  read request.
dout  output  WIDTH  read data, registered.
dout_valid  output  1  one-cycle pulse: dout holds newly popped word.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_LEVEL.
almost_empty  output  1  count <= AE_LEVEL.
count  output  CBITS  current occupancy 0..DEPTH.
overflow  output  1  sticky: push attempted and rejected.
underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (reset_n low, async): wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0. Flags are decoded from count, so empty=1, full=0, almost_empty=1, almost_full=0 (with defaults). RAM contents are not reset.
- Pointer advance: ptr==DEPTH-1 wraps to 0, otherwise ptr+1. Valid for any DEPTH.
- Pop acceptance: pop_ok = pop && !empty.
- Push acceptance: push_ok = push && (!full || pop_ok). At full, a push is accepted only when a pop is accepted in the same cycle.
- Accepted push: mem[wr_ptr] <= din; wr_ptr advances.
- Accepted pop: dout <= mem[rd_ptr]; rd_ptr advances; dout_valid=1 next cycle. Read latency is 1 cycle from the accepted pop edge.
- dout holds its last value when no pop is accepted. dout_valid is 0 on any cycle without an accepted pop at the previous edge.
- Count update:
  - +1 on push_ok only
  - -1 on pop_ok only
  - unchanged when both or neither are accepted
- Empty with push and pop together: push is accepted and pop is rejected (no bypass). Count becomes 1 and underflow sets.
- Error flags:
  - overflow sets on push && !push_ok.
  - underflow sets on pop && empty.
  - Both hold until clear or reset.
- clear=1: pointers=0, count=0, overflow=0, underflow=0, dout_valid=0. push/pop that cycle are ignored and do not set error flags. dout retains its value.
- All flags are registered or decoded from registered count. No combinational path from push/pop to full/empty.
- Reset mid-operation: any pending dout_valid pulse is cancelled and the FIFO reads empty immediately (async).
- Storage is inferred as block RAM: a registered read port with no read-enable-dependent reset on the array.

Test Plan:
1. WIDTH=16, DEPTH=8: push 0x1111,0x2222,0x3333,0x4444 then pop x4 -> dout sequence 0x1111..0x4444, each 1 cycle after its pop, dout_valid pulses x4, count 4→0, empty=1 at end.
2. DEPTH=8: push 9 words back-to-back -> full=1 after 8th, 9th rejected, overflow=1 and stays set, count=8. Then pop 8 -> data 1..8 in order, underflow=0.
3. Full FIFO (DEPTH=8), push=1 and pop=1 same cycle with din=0xABCD -> count stays 8, overflow=0. After 7 more pops, 8th pop returns 0xABCD.
4. DEPTH=6 (non-power-of-2), 20 cycles alternating push x3/pop x3 of incrementing data -> order preserved across wrap, count never exceeds 3. Pointers visit 0..5 only (bench monitors hierarchically).
5. Empty FIFO, pop=1 -> underflow=1, dout_valid stays 0, dout unchanged. Same cycle push=1 din=0x55 -> count=1. Next pop returns 0x55.
6. Count=5 with overflow set: assert clear for 1 cycle -> count=0, empty=1, overflow=0. Separately, drop reset_n mid-burst -> all outputs reach reset values without a clock edge.
